// File: rtl/raster_pkg.sv
// Shared raster-stage types: walker state, MSAA one-hot encodings and the
// mapping from MSAA mode to subsample step shift.
package raster_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } walk_state_e;

  localparam logic [3:0] MSAA_1X  = 4'b1000;
  localparam logic [3:0] MSAA_4X  = 4'b0100;
  localparam logic [3:0] MSAA_16X = 4'b0010;
  localparam logic [3:0] MSAA_64X = 4'b0001;

  // Unknown or zero encodings fall back to 1x so the walk always terminates.
  function automatic logic [1:0] step_shift(input logic [3:0] sub_sample);
    logic [1:0] k;
    case (sub_sample)
      MSAA_1X:  k = 2'd0;
      MSAA_4X:  k = 2'd1;
      MSAA_16X: k = 2'd2;
      MSAA_64X: k = 2'd3;
      default:  k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sample_step.sv
// Next-sample arithmetic for the raster walker: advances x, and signals a
// row wrap or the end of the box. Sums are one bit wider so they cannot wrap.
module sample_step #(
  parameter int SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] cur_x,
  input  logic signed [SIGFIG-1:0] cur_y,
  input  logic signed [SIGFIG-1:0] ur_x,
  input  logic signed [SIGFIG-1:0] ur_y,
  input  logic signed [SIGFIG:0]   step,
  output logic signed [SIGFIG-1:0] next_x,
  output logic signed [SIGFIG-1:0] next_y,
  output logic                     row_wrap,
  output logic                     last
);

  logic signed [SIGFIG:0] nx_s;
  logic signed [SIGFIG:0] ny_s;
  logic                   in_row_s;
  logic                   in_col_s;

  assign nx_s     = {cur_x[SIGFIG-1], cur_x} + step;
  assign ny_s     = {cur_y[SIGFIG-1], cur_y} + step;
  assign in_row_s = (nx_s <= {ur_x[SIGFIG-1], ur_x});
  assign in_col_s = (ny_s <= {ur_y[SIGFIG-1], ur_y});
  assign next_x   = nx_s[SIGFIG-1:0];
  assign next_y   = ny_s[SIGFIG-1:0];

  // Classify the step: stay in row, wrap to the next row, or finish.
  always_comb begin
    row_wrap = 1'b0;
    last     = 1'b0;
    if (in_row_s) begin
      row_wrap = 1'b0;
      last     = 1'b0;
    end else if (in_col_s) begin
      row_wrap = 1'b1;
      last     = 1'b0;
    end else begin
      row_wrap = 1'b0;
      last     = 1'b1;
    end
  end

endmodule

// File: rtl/sample_walker.sv
// Raster iterator: latches one triangle and its bounding box, then emits one
// subsample location per cycle in row-major order while holding upstream off.
module sample_walker
  import raster_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R13S,
  input  logic                                           validTri_R13H,
  input  logic        [3:0]                              subSample_RnnnnU,
  output logic                                           halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                  sample_R14S,
  output logic                                           validSamp_R14H
);

  walk_state_e                                   state_r;
  walk_state_e                                   state_nxt_s;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_r;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_r;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_r;
  logic signed [1:0][SIGFIG-1:0]                 sample_r;
  logic                                          valid_r;
  logic signed [SIGFIG:0]                        step_s;
  logic signed [SIGFIG-1:0]                      next_x_s;
  logic signed [SIGFIG-1:0]                      next_y_s;
  logic                                          row_wrap_s;
  logic                                          last_s;
  logic                                          box_ok_s;
  logic                                          accept_s;

  assign step_s = {{SIGFIG{1'b0}}, 1'b1} << (RADIX - int'(step_shift(subSample_RnnnnU)));

  // Index [0] is lower-left, [1] upper-right; inner index 0 is x, 1 is y.
  assign box_ok_s = ($signed(box_R13S[0][0]) <= $signed(box_R13S[1][0])) &&
                    ($signed(box_R13S[0][1]) <= $signed(box_R13S[1][1]));

  sample_step #(.SIGFIG(SIGFIG)) u_step (
    .cur_x    (sample_r[0]),
    .cur_y    (sample_r[1]),
    .ur_x     (box_r[1][0]),
    .ur_y     (box_r[1][1]),
    .step     (step_s),
    .next_x   (next_x_s),
    .next_y   (next_y_s),
    .row_wrap (row_wrap_s),
    .last     (last_s)
  );

  // Next-state decode; a degenerate box is consumed without leaving WAIT.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      WAIT: begin
        if (validTri_R13H && box_ok_s) begin
          accept_s    = 1'b1;
          state_nxt_s = TEST;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      TEST: begin
        if (last_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = TEST;
        end
      end
      default: state_nxt_s = WAIT;
    endcase
  end

  // State, latched triangle and sample position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= WAIT;
      tri_r    <= '0;
      color_r  <= '0;
      box_r    <= '0;
      sample_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        WAIT: begin
          if (accept_s) begin
            tri_r       <= tri_R13S;
            color_r     <= color_R13U;
            box_r       <= box_R13S;
            sample_r[0] <= box_R13S[0][0];
            sample_r[1] <= box_R13S[0][1];
            valid_r     <= 1'b1;
          end else begin
            valid_r <= 1'b0;
          end
        end
        TEST: begin
          if (last_s) begin
            valid_r <= 1'b0;
          end else if (row_wrap_s) begin
            sample_r[0] <= box_r[0][0];
            sample_r[1] <= next_y_s;
            valid_r     <= 1'b1;
          end else begin
            sample_r[0] <= next_x_s;
            valid_r     <= 1'b1;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign halt_RnnnnL    = (state_r == WAIT);
  assign tri_R14S       = tri_r;
  assign color_R14U     = color_r;
  assign sample_R14S    = sample_r;
  assign validSamp_R14H = valid_r;

endmodule

// File: tb/tb_sample_walker.sv
// Directed self-checking bench for sample_walker: walk order, inclusive
// edges, degenerate boxes, back-to-back bubble and asynchronous reset.
module tb_sample_walker;

  localparam int SIGFIG = 24;

  logic                                    clk;
  logic                                    rst;
  logic signed [2:0][2:0][SIGFIG-1:0]      tri_R13S;
  logic        [2:0][SIGFIG-1:0]           color_R13U;
  logic signed [1:0][1:0][SIGFIG-1:0]      box_R13S;
  logic                                    validTri_R13H;
  logic        [3:0]                       subSample_RnnnnU;
  logic                                    halt_RnnnnL;
  logic signed [2:0][2:0][SIGFIG-1:0]      tri_R14S;
  logic        [2:0][SIGFIG-1:0]           color_R14U;
  logic signed [1:0][SIGFIG-1:0]           sample_R14S;
  logic                                    validSamp_R14H;

  int n_tests = 0;
  int n_fail  = 0;

  sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a triangle at a negedge so the next posedge can accept it.
  task automatic present(input int llx, input int lly, input int urx, input int ury,
                         input logic [23:0] col);
    box_R13S[0][0] = llx[23:0];
    box_R13S[0][1] = lly[23:0];
    box_R13S[1][0] = urx[23:0];
    box_R13S[1][1] = ury[23:0];
    color_R13U     = {col, col ^ 24'h00ffff, col ^ 24'hff0000};
    validTri_R13H  = 1'b1;
  endtask

  // Entered at the negedge where the first sample should be visible; returns
  // at the negedge just after the walk, having checked the bubble there.
  task automatic expect_walk(input string tag, input int llx, input int lly, input int urx,
                             input int ury, input int step, input logic [23:0] col);
    logic [23:0] ex;
    logic [23:0] ey;
    for (int y = lly; y <= ury; y += step) begin
      for (int x = llx; x <= urx; x += step) begin
        ex = x[23:0];
        ey = y[23:0];
        chk({tag, ".valid"}, {31'd0, validSamp_R14H}, 32'd1);
        chk({tag, ".halt"},  {31'd0, halt_RnnnnL},    32'd0);
        chk({tag, ".x"},     {8'd0, sample_R14S[0]},  {8'd0, ex});
        chk({tag, ".y"},     {8'd0, sample_R14S[1]},  {8'd0, ey});
        chk({tag, ".color"}, {8'd0, color_R14U[2]},   {8'd0, col});
        @(negedge clk);
      end
    end
    chk({tag, ".end_valid"}, {31'd0, validSamp_R14H}, 32'd0);
    chk({tag, ".end_halt"},  {31'd0, halt_RnnnnL},    32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    validTri_R13H    = 1'b0;
    subSample_RnnnnU = 4'b1000;
    box_R13S         = '0;
    color_R13U       = '0;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_R13S[v][a] = 24'(v * 16 + a + 1);
    #3;
    chk("rst.halt",  {31'd0, halt_RnnnnL},    32'd1);
    chk("rst.valid", {31'd0, validSamp_R14H}, 32'd0);
    chk("rst.color", {8'd0, color_R14U[0]},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1x, 2x2 grid of 1.0 steps
    present(0, 0, 1024, 1024, 24'h123456);
    @(negedge clk);
    validTri_R13H = 1'b0;
    chk("t1.tri00", {8'd0, tri_R14S[0][0]}, 32'd1);
    chk("t1.tri22", {8'd0, tri_R14S[2][2]}, 32'd35);
    chk("t1.color0", {8'd0, color_R14U[0]}, {8'd0, 24'h123456 ^ 24'hff0000});
    expect_walk("t1", 0, 0, 1024, 1024, 1024, 24'h123456);
    @(negedge clk);

    // 4x, one row of two samples
    subSample_RnnnnU = 4'b0100;
    present(0, 0, 512, 0, 24'h00abcd);
    @(negedge clk);
    validTri_R13H = 1'b0;
    expect_walk("t2", 0, 0, 512, 0, 512, 24'h00abcd);
    @(negedge clk);

    // Single-point box, negative y
    present(2048, -1024, 2048, -1024, 24'h0f0f0f);
    @(negedge clk);
    validTri_R13H = 1'b0;
    expect_walk("t3", 2048, -1024, 2048, -1024, 512, 24'h0f0f0f);
    @(negedge clk);

    // Degenerate box is consumed silently
    subSample_RnnnnU = 4'b1000;
    present(1024, 0, 0, 1024, 24'h777777);
    @(negedge clk);
    validTri_R13H = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4.valid", {31'd0, validSamp_R14H}, 32'd0);
      chk("t4.halt",  {31'd0, halt_RnnnnL},    32'd1);
      @(negedge clk);
    end

    // Second triangle held during the walk: one bubble, then accepted
    present(0, 0, 1024, 1024, 24'haaaaaa);
    @(negedge clk);
    present(0, 0, 1024, 0, 24'h555555);
    expect_walk("t5a", 0, 0, 1024, 1024, 1024, 24'haaaaaa);
    @(negedge clk);
    validTri_R13H = 1'b0;
    expect_walk("t5b", 0, 0, 1024, 0, 1024, 24'h555555);
    @(negedge clk);

    // Asynchronous reset in the middle of a 16-sample walk
    present(0, 0, 3072, 3072, 24'h314159);
    @(negedge clk);
    validTri_R13H = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6.pre_valid", {31'd0, validSamp_R14H}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6.valid", {31'd0, validSamp_R14H}, 32'd0);
    chk("t6.halt",  {31'd0, halt_RnnnnL},    32'd1);
    chk("t6.x",     {8'd0, sample_R14S[0]},  32'd0);
    chk("t6.color", {8'd0, color_R14U[2]},   32'd0);
    chk("t6.tri",   {8'd0, tri_R14S[1][1]},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6.idle_valid", {31'd0, validSamp_R14H}, 32'd0);
    present(1024, 2048, 2048, 2048, 24'h271828);
    @(negedge clk);
    validTri_R13H = 1'b0;
    expect_walk("t6b", 1024, 2048, 2048, 2048, 1024, 24'h271828);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
